// File: rtl/ias_mem_arbiter.sv
// Round-robin arbiter sharing the single-port IAS main memory between the
// instruction-fetch requester (F) and the data requester (D).
module ias_mem_arbiter #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 40,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_e              state_q, state_d;
  logic                owner_q;   // 1 = D owns the current transaction
  logic                last_q;    // 1 = D was granted last
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [3:0]          cnt_q;
  logic [DATA_W-1:0]   f_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (f_gnt || d_gnt) begin
        owner_q <= d_gnt;
        last_q  <= d_gnt;
        we_q    <= d_gnt && d_we;
        addr_q  <= d_gnt ? d_addr : f_addr;
        if (d_gnt) wdata_q <= d_wdata;
      end
      if (state_q == S_ISSUE && !we_q) cnt_q <= LAT;
      if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (owner_q) d_rdata_q <= mem_rdata;
          else         f_rdata_q <= mem_rdata;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (f_gnt || d_gnt) state_d = S_ISSUE;
      S_ISSUE: state_d = we_q ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt_q == 4'd1) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Grants are combinational from IDLE and suppressed while reset is held.
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (state_q == S_IDLE && !reset) begin
      f_gnt = f_req && (!d_req || last_q);
      d_gnt = d_req && (!f_req || !last_q);
    end
    mem_en    = (state_q == S_ISSUE);
    mem_we    = (state_q == S_ISSUE) && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    f_valid   = (state_q == S_RESP) && !owner_q;
    d_valid   = (state_q == S_RESP) && owner_q;
    f_rdata   = f_rdata_q;
    d_rdata   = d_rdata_q;
    busy      = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_ias_mem_arbiter.sv
// Directed bench for ias_mem_arbiter: one instance at MEM_LAT=2, one at MEM_LAT=1.
module tb_ias_mem_arbiter;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 40;
  localparam logic [DW-1:0] BAD = 40'hBA_DBAD_BAD0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic f_req, d_req, d_we;
  logic [AW-1:0] f_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic f_gnt0, f_valid0, d_gnt0, d_valid0, mem_en0, mem_we0, busy0;
  logic [DW-1:0] f_rdata0, d_rdata0, mem_wdata0, mem_rdata0;
  logic [AW-1:0] mem_addr0;

  logic f_req1, d_req1, d_we1;
  logic [AW-1:0] f_addr1, d_addr1;
  logic [DW-1:0] d_wdata1;
  logic f_gnt1, f_valid1, d_gnt1, d_valid1, mem_en1, mem_we1, busy1;
  logic [DW-1:0] f_rdata1, d_rdata1, mem_wdata1, mem_rdata1;
  logic [AW-1:0] mem_addr1;

  ias_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2)) dut0 (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt0), .f_valid(f_valid0), .f_rdata(f_rdata0),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt0), .d_valid(d_valid0), .d_rdata(d_rdata0),
    .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata0), .busy(busy0)
  );

  ias_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .f_req(f_req1), .f_addr(f_addr1), .f_gnt(f_gnt1), .f_valid(f_valid1), .f_rdata(f_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_gnt(d_gnt1), .d_valid(d_valid1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  // Memory models: read data is valid only exactly MEM_LAT cycles after mem_en.
  logic [DW-1:0] mem0 [4096];
  logic [AW-1:0] p0a [2];
  logic [1:0]    p0v;
  always @(posedge clk) begin
    if (reset) begin
      p0v <= '0;
      mem0[12'h005] <= 40'h00_0100_0203;
    end else begin
      p0v <= {p0v[0], mem_en0 & ~mem_we0};
      if (mem_en0 && mem_we0) mem0[mem_addr0] <= mem_wdata0;
    end
    p0a[0] <= mem_addr0;
    p0a[1] <= p0a[0];
  end
  assign mem_rdata0 = p0v[1] ? mem0[p0a[1]] : BAD;

  logic [DW-1:0] mem1 [4096];
  logic [AW-1:0] p1a;
  logic          p1v;
  always @(posedge clk) begin
    if (reset) begin
      p1v <= 1'b0;
      mem1[12'hFFF] <= 40'hFF_FFFF_FFFF;
    end else begin
      p1v <= mem_en1 & ~mem_we1;
      if (mem_en1 && mem_we1) mem1[mem_addr1] <= mem_wdata1;
    end
    p1a <= mem_addr1;
  end
  assign mem_rdata1 = p1v ? mem1[p1a] : BAD;

  int n_memen = 0, n_fvalid = 0, n_dgnt = 0, n_dual = 0;
  always @(negedge clk) begin
    if (mem_en0) n_memen <= n_memen + 1;
    if (f_valid0) n_fvalid <= n_fvalid + 1;
    if (d_gnt0) n_dgnt <= n_dgnt + 1;
    if ((f_gnt0 && d_gnt0) || (f_valid0 && d_valid0)) n_dual <= n_dual + 1;
  end

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int gcyc [4];
  logic [7:0] gwho [4];
  int ng, base_me, base_fv, base_dg;

  initial begin
    reset = 1'b1;
    f_req = 0; d_req = 0; d_we = 0; f_addr = '0; d_addr = '0; d_wdata = '0;
    f_req1 = 0; d_req1 = 0; d_we1 = 0; f_addr1 = '0; d_addr1 = '0; d_wdata1 = '0;

    // Reset state; a request under reset must not be granted
    cyc();
    cyc(); f_req = 1; f_addr = 12'h005; #1;
    check("rst_busy", busy0, 0);
    check("rst_mem_en", mem_en0, 0);
    check("rst_mem_addr", mem_addr0, 0);
    check("rst_mem_wdata", mem_wdata0, 0);
    check("rst_f_rdata", f_rdata0, 0);
    check("rst_d_rdata", d_rdata0, 0);
    check("rst_f_gnt", f_gnt0, 0);

    // Fetch read, MEM_LAT=2
    cyc(); reset = 0; #1;
    check("f_gnt_c0", f_gnt0, 1);
    check("d_gnt_c0", d_gnt0, 0);
    cyc(); f_req = 0; #1;
    check("f_mem_en_c1", mem_en0, 1);
    check("f_mem_addr_c1", mem_addr0, 12'h005);
    check("f_mem_we_c1", mem_we0, 0);
    check("f_busy_c1", busy0, 1);
    cyc(); #1;
    check("f_mem_en_c2", mem_en0, 0);
    check("f_busy_c2", busy0, 1);
    cyc(); #1;
    check("f_valid_c3", f_valid0, 0);
    cyc(); #1;
    check("f_valid_c4", f_valid0, 1);
    check("f_rdata_c4", f_rdata0, 40'h00_0100_0203);
    check("f_busy_c4", busy0, 1);
    cyc(); #1;
    check("f_busy_c5", busy0, 0);
    check("f_valid_c5", f_valid0, 0);

    // Data write
    cyc(); d_req = 1; d_we = 1; d_addr = 12'h010; d_wdata = 40'h12_3456_789A; #1;
    check("w_d_gnt", d_gnt0, 1);
    check("w_f_gnt", f_gnt0, 0);
    cyc(); d_req = 0; d_we = 0; #1;
    check("w_mem_en", mem_en0, 1);
    check("w_mem_we", mem_we0, 1);
    check("w_mem_addr", mem_addr0, 12'h010);
    check("w_mem_wdata", mem_wdata0, 40'h12_3456_789A);
    cyc(); #1;
    check("w_d_valid", d_valid0, 1);
    check("w_d_rdata", d_rdata0, 0);
    check("w_mem_en_c2", mem_en0, 0);
    check("w_addr_hold", mem_addr0, 12'h010);
    cyc(); #1;
    check("w_busy_c3", busy0, 0);
    check("w_mem_stored", mem0[12'h010], 40'h12_3456_789A);

    // Contention from reset release: F read and D write alternate
    cyc(); reset = 1;
    cyc(); reset = 0; f_req = 1; f_addr = 12'h005;
    d_req = 1; d_we = 1; d_addr = 12'h020; d_wdata = 40'h0A_0B0C_0D0E;
    ng = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (f_gnt0 && ng < 4) begin gwho[ng] = "F"; gcyc[ng] = i; ng++; end
      if (d_gnt0 && ng < 4) begin gwho[ng] = "D"; gcyc[ng] = i; ng++; end
      cyc();
    end
    f_req = 0; d_req = 0; d_we = 0; #1;
    check("rr_count", ng, 4);
    check("rr_who0", gwho[0], "F");
    check("rr_who1", gwho[1], "D");
    check("rr_who2", gwho[2], "F");
    check("rr_who3", gwho[3], "D");
    check("rr_cyc0", gcyc[0], 0);
    check("rr_cyc1", gcyc[1], 5);
    check("rr_cyc2", gcyc[2], 8);
    check("rr_cyc3", gcyc[3], 13);
    check("rr_idle", busy0, 0);

    // Reset during WAIT drops the fetch
    cyc(); f_req = 1; f_addr = 12'h005; #1;
    check("rw_f_gnt", f_gnt0, 1);
    base_fv = n_fvalid;
    cyc(); f_req = 0;
    cyc(); reset = 1; #1;
    check("rw_busy_wait", busy0, 1);
    cyc(); d_req = 1; d_we = 0; d_addr = 12'h010; #1;
    check("rw_busy", busy0, 0);
    check("rw_mem_en", mem_en0, 0);
    check("rw_d_gnt_in_rst", d_gnt0, 0);
    check("rw_f_rdata", f_rdata0, 0);
    check("rw_d_rdata", d_rdata0, 0);
    check("rw_mem_addr", mem_addr0, 0);
    check("rw_mem_wdata", mem_wdata0, 0);
    base_me = n_memen;
    cyc(); reset = 0; #1;
    check("rw_d_gnt", d_gnt0, 1);
    cyc(); d_req = 0; #1;
    check("rw_mem_en_rd", mem_en0, 1);
    check("rw_mem_addr_rd", mem_addr0, 12'h010);
    cyc(); cyc(); cyc(); #1;
    check("rw_d_valid", d_valid0, 1);
    check("rw_d_rdata_rd", d_rdata0, 40'h12_3456_789A);
    cyc(); #1;
    check("rw_no_f_valid", n_fvalid - base_fv, 0);
    check("rw_memen_cnt", n_memen - base_me, 1);

    // Short D pulse during WAIT is withdrawn without effect
    cyc(); f_req = 1; f_addr = 12'h005; #1;
    check("wd_f_gnt", f_gnt0, 1);
    base_dg = n_dgnt;
    base_me = n_memen;
    cyc(); f_req = 0;
    cyc(); d_req = 1; d_we = 0; d_addr = 12'h020; #1;
    check("wd_d_gnt_wait", d_gnt0, 0);
    cyc(); d_req = 0;
    cyc(); #1;
    check("wd_f_valid", f_valid0, 1);
    check("wd_f_rdata", f_rdata0, 40'h00_0100_0203);
    cyc(); cyc(); #1;
    check("wd_idle", busy0, 0);
    check("wd_no_d_gnt", n_dgnt - base_dg, 0);
    check("wd_memen_cnt", n_memen - base_me, 1);

    // MEM_LAT=1 data read at the top address
    cyc(); d_req1 = 1; d_we1 = 0; d_addr1 = 12'hFFF; #1;
    check("l1_d_gnt", d_gnt1, 1);
    cyc(); d_req1 = 0; #1;
    check("l1_mem_en", mem_en1, 1);
    check("l1_mem_addr", mem_addr1, 12'hFFF);
    cyc(); #1;
    check("l1_d_valid_c2", d_valid1, 0);
    cyc(); #1;
    check("l1_d_valid_c3", d_valid1, 1);
    check("l1_d_rdata", d_rdata1, 40'hFF_FFFF_FFFF);
    check("l1_f_rdata", f_rdata1, 0);

    check("one_gnt_valid", n_dual, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
